// File: rtl/prime_pkg.sv
// Shared types and constants for the keypad primality tester.
package prime_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_DECOMP    = 3'd2,
    S_POW       = 3'd3,
    S_SQUARE    = 3'd4,
    S_NEXT_BASE = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'd15;

  // Miller-Rabin witnesses, index 0 first; exact for n < 3,215,031,751.
  localparam logic [3:0][3:0] BASES = {4'd7, 4'd5, 4'd3, 4'd2};
  localparam int NUM_BASES = 4;

  // Decimal digit to {dp,g,f,e,d,c,b,a}, active-high.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/mod_mul.sv
// Sequential (a*b) mod n, MSB-first shift-add. Requires a < n.
// One bit of b per cycle: 30 iterations after start, done pulses with p valid.
module mod_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        start,
  input  logic [29:0] a,
  input  logic [29:0] b,
  input  logic [29:0] n,
  output logic        done,
  output logic [29:0] p
);

  logic        busy;
  logic [4:0]  cnt;
  logic [29:0] bq;
  logic [30:0] t;

  // One iteration: r = (2r + b_msb*a) mod n, each partial kept below n.
  always_comb begin
    t = {p, 1'b0};
    if (t >= {1'b0, n}) t = t - {1'b0, n};
    if (bq[29]) t = t + {1'b0, a};
    if (t >= {1'b0, n}) t = t - {1'b0, n};
  end

  // Iteration counter and accumulator; clr drops an in-flight product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      bq   <= '0;
      p    <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        busy <= 1'b0;
      end else if (start) begin
        busy <= 1'b1;
        cnt  <= '0;
        bq   <= b;
        p    <= '0;
      end else if (busy) begin
        p   <= t[29:0];
        bq  <= {bq[28:0], 1'b0};
        cnt <= cnt + 5'd1;
        if (cnt == 5'd29) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/detect_prime_ctrl.sv
// Keypad entry, Miller-Rabin controller and 7-segment mux for the prime tester.
module detect_prime_ctrl
  import prime_pkg::*;
#(
  parameter int SCAN_DIV    = 1,
  parameter int REFRESH_DIV = 1024,
  parameter int MAX_DIGITS  = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [2:0]  key_col,
  output logic [3:0]  key_row,
  output logic [7:0]  oS_COM,
  output logic [7:0]  oS_ENS,
  output logic        LED1,
  output logic        LED2,
  output logic        LED3,
  output logic [35:0] bcd,
  output logic [63:0] bin
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [3:0] MAXD = 4'(MAX_DIGITS);

  // keypad scan
  logic [SCAN_W-1:0] scan_cnt;
  logic              row_end, press, row_hit, held, key_vld;
  logic [1:0]        quiet_cnt, col_idx;
  logic [3:0]        code, key_code;

  // entry and test state
  state_e      state;
  logic [35:0] bcd_r;
  logic [29:0] bin_r, d_r, x, pb, e, ma, mb, mul_p;
  logic [3:0]  cnt;
  logic [4:0]  s_r, sq_left;
  logic [2:0]  bidx;
  logic        mdone, mul_wait, mul_start, mul_done;
  logic [29:0] n_m1, base;

  // display
  logic [REF_W-1:0] ref_cnt;
  logic [2:0]       slot;
  logic [35:0]      bcd_sh;

  assign row_end = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign press   = |key_col;
  assign n_m1    = bin_r - 30'd1;
  assign base    = {26'd0, BASES[bidx[1:0]]};
  assign bcd     = bcd_r;
  assign bin     = {34'd0, bin_r};

  // Decode the key under the current row; leftmost column wins.
  always_comb begin
    col_idx = key_col[2] ? 2'd0 : (key_col[1] ? 2'd1 : 2'd2);
    code    = KEY_NONE;
    case (key_row)
      4'b1000: code = 4'd1 + {2'd0, col_idx};
      4'b0100: code = 4'd4 + {2'd0, col_idx};
      4'b0010: code = 4'd7 + {2'd0, col_idx};
      4'b0001: code = (col_idx == 2'd0) ? KEY_STAR : ((col_idx == 2'd1) ? 4'd0 : KEY_HASH);
      default: code = KEY_NONE;
    endcase
    if (!press) code = KEY_NONE;
  end

  // Row rotation and one-shot press detection; held drops after four clean rows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_row   <= 4'b1000;
      scan_cnt  <= '0;
      row_hit   <= 1'b0;
      quiet_cnt <= '0;
      held      <= 1'b0;
      key_vld   <= 1'b0;
      key_code  <= KEY_NONE;
    end else begin
      key_vld <= 1'b0;
      if (press && !held) begin
        key_vld  <= 1'b1;
        key_code <= code;
        held     <= 1'b1;
      end
      if (row_end) begin
        scan_cnt <= '0;
        key_row  <= {key_row[0], key_row[3:1]};
        row_hit  <= 1'b0;
        if (row_hit || press)       quiet_cnt <= '0;
        else if (quiet_cnt == 2'd3) held      <= 1'b0;
        else                        quiet_cnt <= quiet_cnt + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
        if (press) row_hit <= 1'b1;
      end
    end
  end

  mod_mul u_mul (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .start (mul_start),
    .a     (ma),
    .b     (mb),
    .n     (bin_r),
    .done  (mul_done),
    .p     (mul_p)
  );

  // Entry registers plus the Miller-Rabin sequencer; flush overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      bcd_r <= '0;  bin_r <= '0;  cnt <= '0;
      LED1  <= 1'b0; LED2 <= 1'b0; LED3 <= 1'b0;
      d_r   <= '0;  s_r <= '0;  sq_left <= '0;
      x     <= '0;  pb <= '0;  e <= '0;  bidx <= '0;
      mdone <= 1'b0; mul_wait <= 1'b0; mul_start <= 1'b0;
      ma    <= '0;  mb <= '0;
    end else begin
      mul_start <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
        bcd_r <= '0; bin_r <= '0; cnt <= '0;
        LED1  <= 1'b0; LED2 <= 1'b0; LED3 <= 1'b0;
        mul_wait <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (key_vld) begin
            if (key_code <= 4'd9) begin
              if (cnt < MAXD) begin
                bcd_r <= {bcd_r[31:0], key_code};
                bin_r <= bin_r * 30'd10 + {26'd0, key_code};
                cnt   <= cnt + 4'd1;
                LED1  <= 1'b0; LED2 <= 1'b0;
              end
            end else if (key_code == KEY_STAR) begin
              bcd_r <= '0; bin_r <= '0; cnt <= '0;
              LED1  <= 1'b0; LED2 <= 1'b0;
            end else if (key_code == KEY_HASH) begin
              LED1  <= 1'b0; LED2 <= 1'b0; LED3 <= 1'b1;
              state <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (bin_r < 30'd2) begin
              LED2 <= 1'b1; LED3 <= 1'b0; state <= S_DONE;
            end else if (bin_r == 30'd2 || bin_r == 30'd3 || bin_r == 30'd5 || bin_r == 30'd7) begin
              LED1 <= 1'b1; LED3 <= 1'b0; state <= S_DONE;
            end else if (!bin_r[0]) begin
              LED2 <= 1'b1; LED3 <= 1'b0; state <= S_DONE;
            end else begin
              d_r   <= n_m1;
              s_r   <= '0;
              bidx  <= '0;
              state <= S_DECOMP;
            end
          end
          // n-1 = d * 2^s with d odd
          S_DECOMP: begin
            if (!d_r[0]) begin
              d_r <= {1'b0, d_r[29:1]};
              s_r <= s_r + 5'd1;
            end else begin
              state <= S_NEXT_BASE;
            end
          end
          S_NEXT_BASE: begin
            if (bidx == 3'(NUM_BASES)) begin
              LED1 <= 1'b1; LED3 <= 1'b0; state <= S_DONE;
            end else if (base == bin_r) begin
              bidx <= bidx + 3'd1;
            end else begin
              x     <= 30'd1;
              pb    <= base;
              e     <= d_r;
              mdone <= 1'b0;
              state <= S_POW;
            end
          end
          // LSB-first square-and-multiply; mdone marks that this bit's multiply is folded in
          S_POW: begin
            if (!mul_wait) begin
              if (e == '0) begin
                if (x == 30'd1 || x == n_m1) begin
                  bidx  <= bidx + 3'd1;
                  state <= S_NEXT_BASE;
                end else if (s_r == 5'd1) begin
                  LED2 <= 1'b1; LED3 <= 1'b0; state <= S_DONE;
                end else begin
                  sq_left <= s_r - 5'd1;
                  state   <= S_SQUARE;
                end
              end else begin
                mul_wait  <= 1'b1;
                mul_start <= 1'b1;
                ma        <= (e[0] && !mdone) ? x : pb;
                mb        <= pb;
              end
            end else if (mul_done) begin
              mul_wait <= 1'b0;
              if (e[0] && !mdone) begin
                x     <= mul_p;
                mdone <= 1'b1;
              end else begin
                pb    <= mul_p;
                e     <= {1'b0, e[29:1]};
                mdone <= 1'b0;
              end
            end
          end
          S_SQUARE: begin
            if (!mul_wait) begin
              mul_wait  <= 1'b1;
              mul_start <= 1'b1;
              ma        <= x;
              mb        <= x;
            end else if (mul_done) begin
              mul_wait <= 1'b0;
              x        <= mul_p;
              if (mul_p == n_m1) begin
                bidx  <= bidx + 3'd1;
                state <= S_NEXT_BASE;
              end else if (sq_left == 5'd1) begin
                LED2 <= 1'b1; LED3 <= 1'b0; state <= S_DONE;
              end else begin
                sq_left <= sq_left - 5'd1;
              end
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Slot for the currently lit digit; anything above it all-zero means leading blank.
  assign bcd_sh = bcd_r >> {slot, 2'b00};

  // Digit multiplexer: advance slot every REFRESH_DIV cycles, register COM/ENS together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt <= '0;
      slot    <= '0;
      oS_COM  <= 8'hFE;
      oS_ENS  <= 8'h00;
    end else begin
      if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
        ref_cnt <= '0;
        slot    <= slot + 3'd1;
      end else begin
        ref_cnt <= ref_cnt + REF_W'(1);
      end
      oS_COM <= ~(8'd1 << slot);
      oS_ENS <= (slot != 3'd0 && bcd_sh == '0) ? 8'h00 : seg7(bcd_sh[3:0]);
    end
  end

endmodule

// File: tb/tb_detect_prime_ctrl.sv
// Directed bench for detect_prime_ctrl with a keypad model driven off key_row.
module tb_detect_prime_ctrl;

  logic        clk = 1'b0, rst = 1'b0, flush = 1'b0;
  logic [2:0]  key_col;
  logic [3:0]  key_row;
  logic [7:0]  oS_COM, oS_ENS;
  logic        LED1, LED2, LED3;
  logic [35:0] bcd;
  logic [63:0] bin;

  logic        kp_on = 1'b0;
  logic [3:0]  kp_row = 4'b0000;
  logic [2:0]  kp_col = 3'b000;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // A pressed switch only conducts while its row is driven.
  assign key_col = (kp_on && key_row == kp_row) ? kp_col : 3'b000;

  detect_prime_ctrl #(.SCAN_DIV(1), .REFRESH_DIV(4), .MAX_DIGITS(9)) dut (
    .clk(clk), .rst(rst), .flush(flush), .key_col(key_col), .key_row(key_row),
    .oS_COM(oS_COM), .oS_ENS(oS_ENS), .LED1(LED1), .LED2(LED2), .LED3(LED3),
    .bcd(bcd), .bin(bin)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] r, input logic [2:0] c, input int n);
    @(negedge clk);
    kp_row = r; kp_col = c; kp_on = 1'b1;
    idle(n);
    kp_on = 1'b0;
    idle(8);
  endtask

  // 0..9 digits, 10 = '*', 11 = '#'
  task automatic key(input int k);
    logic [3:0] r;
    logic [2:0] c;
    logic [3:0] top_row;
    logic [2:0] left_col;
    top_row  = 4'b1000;
    left_col = 3'b100;
    if (k == 0)       begin r = 4'b0001; c = 3'b010; end
    else if (k == 10) begin r = 4'b0001; c = 3'b100; end
    else if (k == 11) begin r = 4'b0001; c = 3'b001; end
    else begin
      r = top_row >> ((k - 1) / 3);
      c = left_col >> ((k - 1) % 3);
    end
    press(r, c, 6);
  endtask

  task automatic enter(input longint v);
    int dg[$];
    longint t;
    t = v;
    if (t == 0) dg.push_front(0);
    while (t > 0) begin
      dg.push_front(int'(t % 10));
      t = t / 10;
    end
    key(10);
    foreach (dg[i]) key(dg[i]);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (LED3 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {63'd0, LED3}, 64'd0);
  endtask

  task automatic wait_com(input string tag, input logic [7:0] com, input logic [7:0] exp);
    int n;
    n = 0;
    while (oS_COM !== com && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_com"}, {56'd0, oS_COM}, {56'd0, com});
    chk({tag, "_ens"}, {56'd0, oS_ENS}, {56'd0, exp});
  endtask

  longint nums[4]  = '{64'd100003679, 64'd561, 64'd1, 64'd2};
  logic   prime[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    // reset values while rst is held low
    idle(3);
    chk("rst_row", {60'd0, key_row}, 64'h8);
    chk("rst_bcd", {28'd0, bcd}, 64'd0);
    chk("rst_bin", bin, 64'd0);
    chk("rst_led", {61'd0, LED1, LED2, LED3}, 64'd0);
    chk("rst_com", {56'd0, oS_COM}, 64'hFE);
    chk("rst_ens", {56'd0, oS_ENS}, 64'h00);
    rst = 1'b1;
    idle(5);

    // raw keypad presses: '1' for 5 cycles, '9' for 10 cycles
    press(4'b1000, 3'b100, 5);
    press(4'b0010, 3'b001, 10);
    chk("entry19_bcd", {28'd0, bcd}, 64'h19);
    chk("entry19_bin", bin, 64'd19);

    // display: 9 on slot 0, 1 on slot 1, slot 2 blanked
    wait_com("disp0", 8'hFE, 8'h6F);
    wait_com("disp1", 8'hFD, 8'h06);
    wait_com("disp2", 8'hFB, 8'h00);

    // test 19
    key(11);
    chk("t19_busy", {63'd0, LED3}, 64'd1);
    wait_done("t19_done");
    chk("t19_res", {62'd0, LED1, LED2}, 64'b10);

    // result table; the first run also checks that keys are ignored while busy
    for (int i = 0; i < 4; i++) begin
      enter(nums[i]);
      key(11);
      if (i == 0) begin
        chk("busy_led3", {63'd0, LED3}, 64'd1);
        press(4'b1000, 3'b100, 6);
        chk("busy_bcd", {28'd0, bcd}, 64'h100003679);
      end
      wait_done($sformatf("n%0d_done", nums[i]));
      chk($sformatf("n%0d_res", nums[i]), {62'd0, LED1, LED2},
          prime[i] ? 64'b10 : 64'b01);
    end

    // ten digits: tenth is dropped
    key(10);
    for (int k = 1; k <= 10; k++) key(k % 10);
    chk("max_bcd", {28'd0, bcd}, 64'h123456789);
    chk("max_bin", bin, 64'd123456789);
    key(10);
    chk("star_bcd", {28'd0, bcd}, 64'd0);
    chk("star_bin", bin, 64'd0);

    // long hold enters exactly one '5'
    press(4'b0100, 3'b010, 50);
    chk("hold_bcd", {28'd0, bcd}, 64'h5);
    chk("hold_bin", bin, 64'd5);

    // flush mid-test
    enter(999999937);
    key(11);
    idle(100);
    chk("fl_busy", {63'd0, LED3}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_led3", {63'd0, LED3}, 64'd0);
    chk("fl_bin", bin, 64'd0);
    chk("fl_bcd", {28'd0, bcd}, 64'd0);
    idle(300);
    chk("fl_quiet", {61'd0, LED1, LED2, LED3}, 64'd0);

    // async reset mid-test
    enter(19);
    key(11);
    idle(20);
    chk("ar_busy", {63'd0, LED3}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar_row", {60'd0, key_row}, 64'h8);
    chk("ar_bcd", {28'd0, bcd}, 64'd0);
    chk("ar_bin", bin, 64'd0);
    chk("ar_led", {61'd0, LED1, LED2, LED3}, 64'd0);
    chk("ar_com", {56'd0, oS_COM}, 64'hFE);
    chk("ar_ens", {56'd0, oS_ENS}, 64'h00);
    idle(2);
    rst = 1'b1;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
